// File: rtl/iir_voice_sequencer.sv
// Frame sequencer for the shared 8-voice one-pole IIR: feeds each voice, collects O, emits a scaled mono mix.
// Define MIX_SAT_EN to saturate mix_out instead of wrapping when the shifted accumulator leaves 18-bit range.
module iir_voice_sequencer #(
    parameter int NV        = 8,
    parameter int MIX_SHIFT = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic [7:0]         voice_mask,
    output logic [2:0]         v_idx,
    input  logic [17:0]        vin,
    input  logic [35:0]        vdel,
    output logic               f_ena,
    output logic [2:0]         f_sel,
    output logic [17:0]        f_i,
    output logic [35:0]        f_del,
    input  logic [17:0]        f_o,
    output logic [17:0]        mix_out,
    output logic               mix_valid,
    output logic               busy,
    output logic               overrun
);

    // state | meaning
    // IDLE  | waiting for tick
    // SCAN  | inspect voice_mask[v]; latch voice inputs or skip
    // ENA   | f_ena high, filter samples SEL/I/DEL
    // W1    | filter multiply
    // W2    | filter feedback write
    // CAPT  | f_o valid, accumulate
    // DONE  | publish mix
    typedef enum logic [2:0] {IDLE, SCAN, ENA, W1, W2, CAPT, DONE} state_t;

    localparam logic [2:0] LAST_V = 3'(NV - 1);

    state_t             state;
    logic [2:0]         v;
    logic signed [20:0] acc;
    logic signed [20:0] acc_sh;
    logic signed [20:0] fo_ext;
    logic [17:0]        mix_next;

    assign v_idx  = v;
    assign busy   = (state != IDLE);
    assign acc_sh = acc >>> MIX_SHIFT;
    assign fo_ext = {{3{f_o[17]}}, f_o};

    always_comb begin
        mix_next = acc_sh[17:0];
`ifdef MIX_SAT_EN
        if (acc_sh > 21'sd131071)
            mix_next = 18'h1FFFF;
        else if (acc_sh < -21'sd131072)
            mix_next = 18'h20000;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            v         <= 3'd0;
            acc       <= '0;
            f_ena     <= 1'b0;
            f_sel     <= 3'd0;
            f_i       <= '0;
            f_del     <= '0;
            mix_out   <= '0;
            mix_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            f_ena     <= 1'b0;
            mix_valid <= 1'b0;
            // A tick while busy is dropped; the running frame is left untouched.
            if (tick && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (tick) begin
                        state <= SCAN;
                        v     <= 3'd0;
                        acc   <= '0;
                    end
                end
                SCAN: begin
                    if (voice_mask[v]) begin
                        f_i   <= vin;
                        f_del <= vdel;
                        f_sel <= v;
                        f_ena <= 1'b1;
                        state <= ENA;
                    end else if (v == LAST_V) begin
                        state <= DONE;
                    end else begin
                        v <= v + 3'd1;
                    end
                end
                ENA:  state <= W1;
                W1:   state <= W2;
                W2:   state <= CAPT;
                CAPT: begin
                    acc <= acc + fo_ext;
                    if (v == LAST_V) begin
                        state <= DONE;
                    end else begin
                        v     <= v + 3'd1;
                        state <= SCAN;
                    end
                end
                DONE: begin
                    mix_out   <= mix_next;
                    mix_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/iir_voice_sequencer.md
Name: iir_voice_sequencer

Overview:
Upstream sequencer for the shared 8-voice one-pole IIR filter. On each sample tick it walks voices 0..7 and, for each voice, drives SEL/I/DEL and pulses ena. It waits out the filter's 3-clock math, captures the filter output and accumulates it into a scaled mono mix. It also sits downstream of the filter, consuming O, so the filter needs no knowledge of frame timing.

Parameters:
NV, 8, voice count; fixed at 8 to match the 3-bit filter select.
MIX_SHIFT, 3, arithmetic right shift applied to the 21-bit accumulator to form mix_out.

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
tick  in  1  sample-rate strobe, one clk wide
voice_mask  in  8  bit v=1 processes voice v; 0 skips it
v_idx  out  3  current voice index; upstream returns vin/vdel for it combinationally
vin  in  18  signed voice sample for v_idx
vdel  in  36  signed delay/frequency word for v_idx
f_ena  out  1  filter ena, one-clock pulse
f_sel  out  3  filter SEL
f_i  out  18  filter I, registered
f_del  out  36  filter DEL, registered
f_o  in  18  filter O
mix_out  out  18  signed scaled mix
mix_valid  out  1  one-clock pulse, mix_out updated
busy  out  1  high in any state except IDLE
overrun  out  1  sticky: tick arrived while not IDLE

Behaviour:
- Reset (async, wins over everything):
  - state=IDLE, v=0, acc=0.
  - f_ena=0, f_sel=0, f_i=0, f_del=0, mix_out=0, mix_valid=0, overrun=0.
  - The filter's feedback registers are not reset; the sequencer does not attempt to clear them.
- States: IDLE, SCAN, ENA, W1, W2, CAPT, DONE.
- IDLE: on tick, go to SCAN with v=0 and acc=0.
- SCAN:
  - If voice_mask[v]=1: latch f_i<=vin, f_del<=vdel, f_sel<=v, then go to ENA.
  - If voice_mask[v]=0: skip the voice; go to SCAN with v+1, or to DONE if v=7.
- ENA: f_ena=1 for this cycle only; the filter samples ena at the end of ENA.
- W1, W2: the filter computes (prodA at the end of W1, FB written at the end of W2).
- CAPT:
  - f_o is valid in this cycle; acc <= acc + sign-extended f_o.
  - Then go to SCAN with v+1, or to DONE if v=7.
- Hold rule: f_sel, f_i and f_del stay constant from ENA through CAPT inclusive.
- v_idx = v at all times; vin/vdel are sampled only at the SCAN->ENA edge.
- DONE:
  - mix_out <= acc >>> MIX_SHIFT, truncated to 18 bits; see MIX_SAT_EN.
  - mix_valid=1 for the following cycle; go to IDLE.
- Accumulator: 21-bit signed; 8 x 18-bit values cannot overflow it.
- Latency, counting from the edge that samples tick (edge e0):
  - active voice = 5 clocks (SCAN+ENA+W1+W2+CAPT); masked voice = 1 clock.
  - mix_valid goes high at edge e0+41 with all 8 voices active, and at e0+9 with none active.
- Boundaries:
  - tick outside IDLE is ignored, sets overrun, and does not disturb the frame.
  - tick in the same cycle as DONE is also an overrun.
  - voice_mask changes mid-frame take effect on voices not yet scanned.
  - Reset mid-frame aborts immediately. f_ena drops asynchronously, so the filter may complete a calculation already started; its FB entry is updated, but no mix is produced.

Optional Feature:
MIX_SAT_EN:
- Defined: mix_out saturates to +131071 / -131072 when acc >>> MIX_SHIFT exceeds 18-bit range.
- Undefined: the low 18 bits are taken (wrap).
- Irrelevant at MIX_SHIFT=3 (no overflow possible); matters for MIX_SHIFT<3.

Test Plan:
1. Reset asserted mid-frame (during W1 of voice 2) -> busy=0, f_ena=0, mix_valid never pulses, state IDLE the next cycle.
2. All voices active, vin=0x10000, vdel=0, first frame after power-up with the filter instanced -> each captured f_o=65535, acc=524280, mix_out=65535, mix_valid at e0+41.
3. voice_mask=0x00, tick -> mix_valid at e0+9, mix_out=0, f_ena never asserted.
4. voice_mask=0x81 -> exactly two f_ena pulses with f_sel=0 then 7; f_i/f_del stable ENA..CAPT; mix_valid at e0+17.
5. tick re-asserted 10 clocks after start -> overrun=1 (sticky until reset), frame completes with an unchanged result.
6. MIX_SHIFT=0, scenario 2 stimulus:
   - MIX_SAT_EN defined -> mix_out=131071.
   - MIX_SAT_EN undefined -> mix_out=-8 (0x3FFF8).
